// File: rtl/freq_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package freq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Smallest divide ratio that yields a real output period.
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_counter.sv
// Period counter: counts 0..div-1 and wraps; exposes its next value so the
// controller can register outputs aligned with the count.
module freq_div_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] cnt_nx_c,
    output logic             wrap_c
);

    logic [CNT_W-1:0] cnt;

    assign wrap_c = (cnt == div - CNT_W'(1));

    // Next count: clear wins, otherwise advance/wrap while enabled.
    always_comb begin
        cnt_nx_c = cnt;
        if (clr) begin
            cnt_nx_c = '0;
        end else if (en) begin
            cnt_nx_c = wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nx_c;
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable clock divider: FSM, ratio configuration and registered outputs.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_div_out,
    output logic             tick,
    output logic             busy
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] div_act, div_nx;
    logic [CNT_W-1:0] pend_div, pend_nx;
    logic             pend_vld, pv_nx;
    logic             accept, legal, wrap;
    logic             cnt_clr, cnt_en;
    logic [CNT_W-1:0] cnt_nx_c;
    logic             cnt_wrap_c;
    logic             live;
    logic             clk_nx, tick_nx, rdy_nx, err_nx;

    freq_div_counter #(.CNT_W(CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .div      (div_act),
        .cnt_nx_c (cnt_nx_c),
        .wrap_c   (cnt_wrap_c)
    );

    assign accept = cfg_valid && cfg_ready;
    assign legal  = (cfg_div >= CNT_W'(MIN_DIV));
    assign wrap   = (state != ST_IDLE) && cnt_wrap_c;

    // Next state and ratio bookkeeping.
    always_comb begin
        state_nx = state;
        div_nx   = div_act;
        pend_nx  = pend_div;
        pv_nx    = pend_vld;
        unique case (state)
            ST_IDLE:  if (run) state_nx = ST_RUN;
            ST_RUN:   if (!run) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (run) begin
                    state_nx = ST_RUN;
                end else if (wrap) begin
                    state_nx = ST_IDLE;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
        if (state == ST_IDLE) begin
            // No period in flight: ratios take effect immediately.
            if (pend_vld) begin
                div_nx = pend_div;
                pv_nx  = 1'b0;
            end
            if (accept && legal) div_nx = cfg_div;
        end else begin
            // Mid-period: park the new ratio until the period boundary.
            if (wrap && pend_vld) begin
                div_nx = pend_div;
                pv_nx  = 1'b0;
            end
            if (accept && legal) begin
                pend_nx = cfg_div;
                pv_nx   = 1'b1;
            end
        end
    end

    assign cnt_clr = (state_nx == ST_IDLE);
    assign cnt_en  = (state != ST_IDLE);

    // Output values for the coming cycle, aligned with the next count.
    always_comb begin
        live    = (state_nx != ST_IDLE);
        clk_nx  = live && (cnt_nx_c < (div_nx >> 1));
        tick_nx = live && (cnt_nx_c == '0);
        rdy_nx  = !live || !pv_nx;
        err_nx  = accept && !legal;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Ratio registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_act     <= CNT_W'(DEFAULT_DIV);
            pend_div    <= '0;
            pend_vld    <= 1'b0;
            clk_div_out <= 1'b0;
            tick        <= 1'b0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            div_act     <= div_nx;
            pend_div    <= pend_nx;
            pend_vld    <= pv_nx;
            clk_div_out <= clk_nx;
            tick        <= tick_nx;
            busy        <= live;
            cfg_ready   <= rdy_nx;
            cfg_err     <= err_nx;
        end
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl with a cycle-level expected-output queue.
module tb_freq_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = '0;
    logic        cfg_ready, cfg_err, clk_div_out, tick, busy;

    int vectors = 0;
    int miscompares = 0;

    // Expected {clk_div_out, tick, busy, cfg_ready, cfg_err} per cycle.
    logic [4:0] exp_q[$];

    // Behavioural reference state.
    int          m_st;   // 0 idle, 1 run, 2 drain
    int unsigned m_cnt, m_div, m_pend;
    bit          m_pv, m_rdy;

    freq_div_ctrl #(.CNT_W(16), .DEFAULT_DIV(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .clk_div_out (clk_div_out),
        .tick        (tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_div = 10; m_pend = 0; m_pv = 0; m_rdy = 0;
    endtask

    // Advance the reference by one clock edge and queue its outputs.
    task automatic model_step(input bit r, input bit v, input int unsigned d);
        bit acc, ok, wr, err;
        int st_n;
        acc  = v && m_rdy;
        ok   = (d >= 2);
        wr   = (m_st != 0) && (m_cnt == m_div - 1);
        err  = acc && !ok;
        if (m_st == 0)      st_n = r ? 1 : 0;
        else if (m_st == 1) st_n = r ? 1 : 2;
        else                st_n = r ? 1 : (wr ? 0 : 2);
        if (st_n == 0 || m_st == 0) m_cnt = 0;
        else m_cnt = wr ? 0 : m_cnt + 1;
        if (m_st == 0) begin
            if (m_pv) begin m_div = m_pend; m_pv = 0; end
            if (acc && ok) m_div = d;
        end else begin
            if (wr && m_pv) begin m_div = m_pend; m_pv = 0; end
            if (acc && ok) begin m_pend = d; m_pv = 1; end
        end
        m_st  = st_n;
        m_rdy = (m_st == 0) || !m_pv;
        exp_q.push_back({(m_st != 0) && (m_cnt < m_div / 2),
                         (m_st != 0) && (m_cnt == 0),
                         m_st != 0, m_rdy, err});
    endtask

    task automatic check_out();
        logic [4:0] got, exp;
        got = {clk_div_out, tick, busy, cfg_ready, cfg_err};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty got %b required queued entry", got);
        end else begin
            exp = exp_q.pop_front();
            assert (got === exp) else begin
                miscompares++;
                $error("FAIL cycle t=%0t got %b required %b", $time, got, exp);
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [15:0] d);
        run = r; cfg_valid = v; cfg_div = d;
        model_step(r, v, int'(d));
        @(posedge clk); #1;
        check_out();
        cfg_valid = 1'b0;
    endtask

    task automatic expect_int(input string tag, input int got, input int req);
        vectors++;
        assert (got === req) else begin
            miscompares++;
            $error("FAIL %s got %0d required %0d", tag, got, req);
        end
    endtask

    // Wait for a tick, then measure the following period length and high time.
    task automatic measure(input int per, input int hi, input string tag,
                           input int max_wait, output int waited);
        int p, h;
        waited = 0;
        do begin step(1, 0, 0); waited++; end while (!tick && waited < max_wait);
        expect_int({tag, "_tick"}, int'(tick), 1);
        p = 1; h = int'(clk_div_out);
        while (p <= per + 1) begin
            step(1, 0, 0);
            if (tick) break;
            p++; h += int'(clk_div_out);
        end
        expect_int({tag, "_period"}, p, per);
        expect_int({tag, "_high"}, h, hi);
    endtask

    task automatic drain_to_idle();
        int n;
        n = 0;
        do begin step(0, 0, 0); n++; end while (busy && n < 20);
        expect_int("drain_idle", int'(busy), 0);
    endtask

    initial begin
        int w, n;
        model_reset();
        #2;
        expect_int("rst_outs", int'({clk_div_out, tick, busy, cfg_ready, cfg_err}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 0, 0);
        expect_int("rdy_after_rst", int'(cfg_ready), 1);

        // Default ratio: first tick right after run, 10-cycle 5/5 periods.
        measure(10, 5, "div10_a", 2, w);
        expect_int("first_tick_lat", w, 1);
        measure(10, 5, "div10_b", 12, w);

        // Mid-period change to 4: current period finishes at 10.
        repeat (3) step(1, 0, 0);
        step(1, 1, 16'd4);
        expect_int("rdy_pending", int'(cfg_ready), 0);
        measure(4, 2, "div4_a", 8, w);
        expect_int("div4_wrap_wait", w, 6);
        measure(4, 2, "div4_b", 6, w);

        // Illegal ratios 1 and 0.
        step(1, 1, 16'd1);
        expect_int("err_div1", int'(cfg_err), 1);
        step(1, 1, 16'd0);
        expect_int("err_div0", int'(cfg_err), 1);
        step(1, 0, 0);
        expect_int("err_clear", int'(cfg_err), 0);
        measure(4, 2, "div4_after_err", 6, w);

        // Back to 10, then drain starting at cnt = 3.
        step(1, 1, 16'd10);
        measure(10, 5, "div10_c", 8, w);
        repeat (3) step(1, 0, 0);
        n = 0;
        do begin step(0, 0, 0); n++; end while (busy && n < 20);
        expect_int("drain_len", n, 7);
        expect_int("idle_outs", int'({clk_div_out, tick}), 0);

        // Re-raise run during drain at cnt = 7: no break, no extra tick.
        step(1, 0, 0);
        repeat (3) step(1, 0, 0);
        repeat (4) step(0, 0, 0);
        measure(10, 5, "rerun", 12, w);
        expect_int("rerun_wait", w, 3);

        // Asynchronous reset at cnt = 2 with ratio 6 pending.
        step(1, 1, 16'd6);
        step(1, 0, 0);
        #2 reset = 1'b1;
        #1;
        expect_int("async_rst", int'({clk_div_out, tick, busy, cfg_ready, cfg_err}), 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 0, 0);
        measure(10, 5, "post_rst", 2, w);

        // Odd ratio 3 loaded in IDLE.
        drain_to_idle();
        step(0, 1, 16'd3);
        measure(3, 1, "div3_a", 2, w);
        measure(3, 1, "div3_b", 5, w);

        // Largest ratio.
        drain_to_idle();
        step(0, 1, 16'hFFFF);
        measure(65535, 32767, "divmax", 2, w);
        expect_int("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
